// File: rtl/core_pkg.sv
// Shared core definitions: ALU op encodings, branch and M-extension funct3
// codes, the mul/div engine state type and a forwarding-match helper.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // A forwarding source matches only when it writes a nonzero register
    // equal to the operand's register.
    function automatic logic fwd_hit(input logic we, input logic [4:0] src_rd,
                                     input logic [4:0] rs);
        return we && (src_rd != 5'd0) && (src_rd == rs);
    endfunction

endpackage

// File: rtl/stage_ex_md_if.sv
// ID/EX operands, forwarding sources, pipeline control and EX/MEM outputs
// of the execute stage. master = surrounding pipeline, slave = EX stage.
interface stage_ex_md_if #(
    parameter int XLEN = 32
);
    logic            stall_in;
    logic            flush_in;

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_alu_src;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_reg_write;
    logic            id_branch;
    logic            id_jal;
    logic            id_jalr;
    logic            id_md;
    logic [3:0]      id_alu_op;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;

    logic [XLEN-1:0] mem_fwd_data;
    logic [4:0]      mem_fwd_rd;
    logic            mem_fwd_we;
    logic [XLEN-1:0] wb_fwd_data;
    logic [4:0]      wb_fwd_rd;
    logic            wb_fwd_we;

    logic            md_busy;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            ex_valid;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;

    modport master (
        output stall_in, flush_in,
        output id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
        output id_rs1, id_rs2, id_rd,
        output id_alu_src, id_mem_read, id_mem_write, id_reg_write,
        output id_branch, id_jal, id_jalr, id_md, id_alu_op, id_funct3, id_funct7,
        output mem_fwd_data, mem_fwd_rd, mem_fwd_we,
        output wb_fwd_data, wb_fwd_rd, wb_fwd_we,
        input  md_busy, redirect, redirect_pc,
        input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
        input  ex_pc, ex_result, ex_store_data, ex_rd
    );

    modport slave (
        input  stall_in, flush_in,
        input  id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
        input  id_rs1, id_rs2, id_rd,
        input  id_alu_src, id_mem_read, id_mem_write, id_reg_write,
        input  id_branch, id_jal, id_jalr, id_md, id_alu_op, id_funct3, id_funct7,
        input  mem_fwd_data, mem_fwd_rd, mem_fwd_we,
        input  wb_fwd_data, wb_fwd_rd, wb_fwd_we,
        output md_busy, redirect, redirect_pc,
        output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
        output ex_pc, ex_result, ex_store_data, ex_rd
    );

endinterface

// File: rtl/alu.sv
// Integer ALU for the execute stage.
module alu
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    // Operation select.
    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/stage_ex_md_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, sign fix applied on the way out.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | shift-add iterations, counter runs XLEN..1
// DIV   | restoring-divide iterations, counter runs XLEN..1
// DONE  | result valid; waits here while hold is high
module muldiv_iter
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int             CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);

    md_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            neg_res, neg_rem, div_zero;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    // Operand signedness and magnitudes captured at start.
    always_comb begin
        a_signed = (funct3 == MD_MUL) || (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                   (funct3 == MD_DIV) || (funct3 == MD_REM);
        b_signed = (funct3 == MD_MUL) || (funct3 == MD_MULH) ||
                   (funct3 == MD_DIV) || (funct3 == MD_REM);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_abs    = a_neg ? (~op_a + 1'b1) : op_a;
        b_abs    = b_neg ? (~op_b + 1'b1) : op_b;
    end

    // One iteration of each algorithm.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; flush aborts from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = funct3[2] ? DIV : MUL;
            MUL, DIV: if (cnt == CW'(1)) state_nxt = DONE;
            DONE:     if (!hold) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Counter and shift/accumulate registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !flush) begin
                    cnt      <= CNT_LOAD;
                    acc_hi   <= '0;
                    acc_lo   <= a_abs;
                    opnd     <= b_abs;
                    f3_q     <= funct3;
                    rd_q     <= rd_in;
                    neg_res  <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    div_zero <= (op_b == '0);
                end
                MUL: begin
                    cnt    <= cnt - 1'b1;
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
                DIV: begin
                    cnt <= cnt - 1'b1;
                    if (!div_diff[XLEN]) begin
                        acc_hi <= div_diff[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign correction and result select. Divide by zero forces an
    // all-ones quotient; the remainder path already yields the dividend.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? (~prod + 1'b1) : prod;
        quot_fix = div_zero ? '1 : (neg_res ? (~acc_lo + 1'b1) : acc_lo);
        rem_fix  = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
        case (f3_q)
            MD_MUL:                      result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result = quot_fix;
            default:                     result = rem_fix;
        endcase
    end

    assign busy   = (state == MUL) || (state == DIV);
    assign done   = (state == DONE);
    assign rd_out = rd_q;

endmodule

// File: rtl/stage_ex_md.sv
// Execute stage with operand forwarding, branch/jump resolution and an
// optional iterative mul/div engine, registering into the EX/MEM latch.
module stage_ex_md
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter bit MD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    stage_ex_md_if.slave bus
);
    logic [XLEN-1:0] fwd_rs1, fwd_rs2, alu_b, alu_y;
    logic [XLEN-1:0] link_pc, jalr_sum, br_target;
    logic            br_cond, taken, is_md;
    logic            md_idle, md_start, md_eng_busy, md_done;
    logic [XLEN-1:0] md_result;
    logic [4:0]      md_rd;

    logic            ex_valid_q, ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;
    logic [XLEN-1:0] ex_pc_q, ex_result_q, ex_store_data_q;
    logic [4:0]      ex_rd_q;

    // funct7 is already folded into alu_op / id_md by the decoder.
    logic unused_funct7;
    assign unused_funct7 = ^bus.id_funct7;

    // Operand forwarding, MEM source ahead of WB.
    always_comb begin
        fwd_rs1 = bus.id_rs1_val;
        if (fwd_hit(bus.mem_fwd_we, bus.mem_fwd_rd, bus.id_rs1))
            fwd_rs1 = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_fwd_we, bus.wb_fwd_rd, bus.id_rs1))
            fwd_rs1 = bus.wb_fwd_data;

        fwd_rs2 = bus.id_rs2_val;
        if (fwd_hit(bus.mem_fwd_we, bus.mem_fwd_rd, bus.id_rs2))
            fwd_rs2 = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_fwd_we, bus.wb_fwd_rd, bus.id_rs2))
            fwd_rs2 = bus.wb_fwd_data;
    end

    assign alu_b = bus.id_alu_src ? bus.id_imm : fwd_rs2;

    alu #(.XLEN(XLEN)) u_alu (
        .alu_op (bus.id_alu_op),
        .a      (fwd_rs1),
        .b      (alu_b),
        .y      (alu_y)
    );

    // Branch condition compare.
    always_comb begin
        case (bus.id_funct3)
            BR_BEQ:  br_cond = (fwd_rs1 == fwd_rs2);
            BR_BNE:  br_cond = (fwd_rs1 != fwd_rs2);
            BR_BLT:  br_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            BR_BGE:  br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_BLTU: br_cond = (fwd_rs1 <  fwd_rs2);
            BR_BGEU: br_cond = (fwd_rs1 >= fwd_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    assign taken           = bus.id_branch && br_cond;
    assign link_pc         = bus.id_pc + XLEN'(4);
    assign jalr_sum        = fwd_rs1 + bus.id_imm;
    assign br_target       = bus.id_pc + bus.id_imm;
    assign bus.redirect    = bus.id_valid && !bus.flush_in &&
                             (taken || bus.id_jal || bus.id_jalr);
    assign bus.redirect_pc = bus.id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;

    assign is_md    = MD_EN && bus.id_md;
    assign md_idle  = !md_eng_busy && !md_done;
    assign md_start = bus.id_valid && is_md && !bus.flush_in && md_idle;
    assign bus.md_busy = (md_idle && bus.id_valid && is_md) || md_eng_busy;

    generate
        if (MD_EN) begin : g_md
            muldiv_iter #(.XLEN(XLEN)) u_muldiv (
                .clk     (clk),
                .reset_n (reset_n),
                .start   (md_start),
                .flush   (bus.flush_in),
                .hold    (bus.stall_in),
                .funct3  (bus.id_funct3),
                .rd_in   (bus.id_rd),
                .op_a    (fwd_rs1),
                .op_b    (fwd_rs2),
                .busy    (md_eng_busy),
                .done    (md_done),
                .result  (md_result),
                .rd_out  (md_rd)
            );
        end else begin : g_no_md
            assign md_eng_busy = 1'b0;
            assign md_done     = 1'b0;
            assign md_result   = '0;
            assign md_rd       = '0;
        end
    endgenerate

    // EX/MEM latch: flush beats stall; a finished mul/div retires only
    // when not stalled; an engine in flight loads bubbles.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush_in) begin
            ex_valid_q      <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_pc_q         <= '0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= '0;
        end else if (bus.stall_in) begin
            ex_valid_q <= ex_valid_q;
        end else if (md_done) begin
            ex_valid_q      <= 1'b1;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b1;
            ex_pc_q         <= bus.id_pc;
            ex_result_q     <= md_result;
            ex_store_data_q <= '0;
            ex_rd_q         <= md_rd;
        end else if (md_eng_busy || md_start) begin
            ex_valid_q      <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_pc_q         <= '0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= '0;
        end else begin
            ex_valid_q      <= bus.id_valid;
            ex_mem_read_q   <= bus.id_valid && bus.id_mem_read;
            ex_mem_write_q  <= bus.id_valid && bus.id_mem_write;
            ex_reg_write_q  <= bus.id_valid && bus.id_reg_write;
            ex_pc_q         <= bus.id_pc;
            ex_result_q     <= (bus.id_jal || bus.id_jalr) ? link_pc : alu_y;
            ex_store_data_q <= fwd_rs2;
            ex_rd_q         <= bus.id_rd;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_result     = ex_result_q;
    assign bus.ex_store_data = ex_store_data_q;
    assign bus.ex_rd         = ex_rd_q;

endmodule

// File: doc/stage_ex_md.md
# stage_ex_md

Parametrised execute stage that replaces the single-cycle EX stage when the core gains the RV32M extension. Resolves operand forwarding (including forwarded store data), branches and jumps, and runs MUL/MULH*/DIV*/REM* on an iterative multiply/divide engine that stalls the front end while busy. It registers its result into the EX/MEM latch, feeding the MEM stage.

## Interface
- XLEN, 32, datapath width (32 or 64).
- MD_EN, 1, 0 removes the mul/div engine; `id_md` is then ignored and treated as an ALU op.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- stall_in  in  1  downstream hold; EX/MEM latch keeps its value.
- flush_in  in  1  kill the current EX instruction and any mul/div in flight.
- id_valid  in  1  ID/EX holds a real instruction.
- id_pc, id_rs1_val, id_rs2_val, id_imm  in  XLEN each  ID/EX operands.
- id_rs1, id_rs2, id_rd  in  5 each  register numbers.
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jal, id_jalr, id_md  in  1 each  controls; `id_md` marks an M-extension op.
- id_alu_op  in  4  ALU control.
- id_funct3  in  3  and  id_funct7  in  7  subtype fields.
- mem_fwd_data  in  XLEN,  mem_fwd_rd  in  5,  mem_fwd_we  in  1  EX/MEM forwarding source.
- wb_fwd_data  in  XLEN,  wb_fwd_rd  in  5,  wb_fwd_we  in  1  MEM/WB forwarding source.
- md_busy  out  1  combinational; the front end must hold ID/EX while high.
- redirect  out  1  combinational; taken branch, JAL or JALR.
- redirect_pc  out  XLEN  combinational target.
- ex_valid, ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  registered controls.
- ex_pc, ex_result, ex_store_data  out  XLEN each  registered datapath.
- ex_rd  out  5  registered destination register.

## Operation
- Forwarding is applied separately to rs1 and rs2. The MEM source has priority over WB. A source matches only when its `*_we` is high and its rd equals the operand's register and is nonzero; otherwise the register-file value is used.
- ALU operand B is `id_imm` when `id_alu_src` is set, else forwarded rs2. `ex_store_data` always carries forwarded rs2.
- Branch conditions use funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `redirect` = `id_valid` & !`flush_in` & (taken | `id_jal` | `id_jalr`).
- `redirect_pc` is (fwd_rs1 + imm) with bit 0 cleared for JALR, else pc + imm.
- JAL and JALR write pc+4 to `ex_result`.
- Mul/div FSM states are IDLE, MUL, DIV, DONE.
  - IDLE → MUL or DIV when `id_valid` & `id_md` & !`flush_in`. On entry, capture the absolute values of the forwarded operands, the sign-fix flags, funct3 and rd, and load the counter with XLEN.
  - MUL and DIV run one shift-add or restoring-subtract step per cycle and decrement the counter. At counter = 1 the FSM moves to DONE.
  - DONE latches the sign-corrected result into EX/MEM with `ex_valid` = 1, then returns to IDLE. If `stall_in` is high, the FSM stays in DONE.
- M-extension funct3 codes: 000 MUL (low half), 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divide by zero: quotient is all ones, remainder is the dividend. The divider stage still runs its full length.
- Signed overflow (MIN / −1): quotient is MIN, remainder is 0.
- `md_busy` is high for (IDLE & `id_valid` & `id_md`) or MUL or DIV. It is low in DONE, so ID/EX advances in the same edge that retires the result.
- While the FSM is in MUL or DIV, EX/MEM receives bubbles: `ex_valid` = 0 and all controls are 0.

## Timing
- On reset, all registered outputs are 0 and the FSM is IDLE.
- ALU, branch and jump operations have 1-cycle latency: inputs at edge N appear on `ex_*` after edge N+1.
- A mul/div op has XLEN+2 cycles of latency from acceptance to its EX/MEM write; `md_busy` is high for XLEN+1 cycles.
- `flush_in` takes priority over `stall_in`. It loads bubbles into EX/MEM and forces the FSM to IDLE from any state, aborting any result.
- `stall_in` holds EX/MEM. Iterations continue during a stall; only DONE waits for it to clear.
- `stall_in` does not suppress `redirect`. The hazard unit gates redirect using its own stall.
- Reset mid-operation clears the FSM and discards the result.
- Forwarding into an accepted mul/div is sampled once, at acceptance. Later changes on the forwarding inputs do not affect the result.

## Structure
- A shared package `core_pkg` holds:
  - ALU op encodings, branch funct3 codes and M funct3 codes;
  - the `md_state_t` enum {IDLE, MUL, DIV, DONE};
  - the default XLEN.
- Submodule `muldiv_iter` contains the FSM, counter and shift/accumulate registers. It exposes start, flush, busy, done and result.
- Forwarding muxes and branch compare stay inline; the existing `alu` is instantiated unchanged.

## Test plan
- Forwarding: ADD x3,x1,x2 with `mem_fwd_rd` = 1 (data 7) and `wb_fwd_rd` = 1 (data 9), rs2 = 5 → `ex_result` = 12.
- Forwarding from x0: rd = 0 with `we` = 1 → not forwarded; register-file value is used.
- Store forwarding: SW with `wb_fwd_rd` = rs2 and data 0xDEADBEEF → `ex_store_data` = 0xDEADBEEF.
- BNE: rs1 = 4, rs2 = 5, pc = 0x100, imm = 0x20 → `redirect` = 1, `redirect_pc` = 0x120.
- JALR: rs1 = 0x203, imm = 0 → `redirect_pc` = 0x202, `ex_result` = pc+4.
- MULH: −3 × 0x40000000 → `md_busy` high for exactly 33 cycles; `ex_result` = 0xFFFFFFFF; `ex_valid` = 0 during the busy cycles.
- DIV: 7/0 → quotient 0xFFFFFFFF. REM 7/0 → 7. DIV 0x80000000/−1 → 0x80000000. REM of the same → 0.
- Flush at iteration 10 of a DIVU → FSM returns to IDLE, no writeback, `md_busy` low next cycle. A following ADD completes normally.
- `stall_in` held 3 cycles while the FSM is in DONE → result appears on the edge after release. `reset_n` low mid-MUL → all outputs 0 and the FSM is IDLE.
